// File: rtl/maxpool_window_sequencer.sv
// 2x2 stride-2 max-pool window sequencer: buffers the upper row of each row
// pair and presents completed windows to the pooling unit over valid/ready.
module maxpool_window_sequencer #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [DATA_W-1:0] win_p0,
   output logic [DATA_W-1:0] win_p1,
   output logic [DATA_W-1:0] win_p2,
   output logic [DATA_W-1:0] win_p3,
   output logic              win_last,
   output logic              busy,
   output logic              frame_done
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROW   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state;
   logic [ROW_W-1:0]  row_cnt;
   logic [COL_W-1:0]  col_cnt;
   logic [DATA_W-1:0] hold;
   logic [DATA_W-1:0] row_buf [IMG_W];

   logic odd_row;
   logic odd_col;
   logic last_pixel;
   logic xfer;
   logic win_take;
   logic win_load;
   logic [COL_W-1:0] left_col;

   assign odd_row    = row_cnt[0];
   assign odd_col    = col_cnt[0];
   assign last_pixel = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
   assign left_col   = {col_cnt[COL_W-1:1], 1'b0};

   // A completing pixel may only enter when the window slot is free or
   // being freed this cycle; otherwise the pending window would be lost.
   assign in_ready = (state == S_ROW) &&
                     !(odd_row && odd_col && win_valid && !win_ready);

   assign xfer     = in_valid && in_ready;
   assign win_take = win_valid && win_ready;
   assign win_load = xfer && odd_row && odd_col;

   assign busy       = (state == S_ROW) || (state == S_DRAIN);
   assign frame_done = (state == S_DONE);

   // NOTE: sequential state is assigned with <= so every register samples
   // pre-edge values; blocking assignments here would create ordering races.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         row_cnt <= '0;
         col_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  row_cnt <= '0;
                  col_cnt <= '0;
                  state   <= S_ROW;
               end
            end
            S_ROW: begin
               if (xfer) begin
                  if (col_cnt == COL_LAST) begin
                     col_cnt <= '0;
                     row_cnt <= row_cnt + 1'b1;
                  end else begin
                     col_cnt <= col_cnt + 1'b1;
                  end
                  if (last_pixel) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (win_take && win_last) state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold      <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         win_p0    <= '0;
         win_p1    <= '0;
         win_p2    <= '0;
         win_p3    <= '0;
      end else begin
         if (xfer && odd_row && !odd_col) hold <= in_data;

         if (win_load) begin
            win_p0    <= row_buf[left_col];
            win_p1    <= row_buf[col_cnt];
            win_p2    <= hold;
            win_p3    <= in_data;
            win_valid <= 1'b1;
            win_last  <= last_pixel;
         end else if (win_take) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
         end
      end
   end

   // NOTE: the row buffer has no reset; every entry is written on the even
   // row before it is read, so resetting it would only cost logic.
   always_ff @(posedge clk) begin
      if (xfer && !odd_row) row_buf[col_cnt] <= in_data;
   end

endmodule

// File: tb/tb_maxpool_window_sequencer.sv
// Randomized self-checking bench for maxpool_window_sequencer against a
// frame-level reference model built from pixel indices.
module tb_maxpool_window_sequencer;

   localparam int DATA_W = 16;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 4;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int NWIN   = (IMG_W / 2) * (IMG_H / 2);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic              win_valid;
   logic              win_ready = 1'b0;
   logic [DATA_W-1:0] win_p0, win_p1, win_p2, win_p3;
   logic              win_last;
   logic              busy;
   logic              frame_done;

   maxpool_window_sequencer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_p0    (win_p0),
      .win_p1    (win_p1),
      .win_p2    (win_p2),
      .win_p3    (win_p3),
      .win_last  (win_last),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: frame phase, pixels taken, windows produced/accepted.
   typedef enum int {M_IDLE, M_ROW, M_DRAIN, M_DONE} m_phase_t;
   m_phase_t          m_phase = M_IDLE;
   int                m_pix = 0;
   int                m_emit = 0;
   int                m_acc = 0;
   bit                m_just_reset = 1'b0;
   logic [DATA_W-1:0] pix [NPIX];

   // One clock cycle: drive at negedge, check settled outputs, advance model.
   task automatic run_cycle(input bit rst, input bit st, input bit iv,
                            input logic [DATA_W-1:0] d, input bit wr);
      bit pending, exp_rdy, take, odd_r, odd_c;
      int k, top;
      @(negedge clk);
      reset = rst; start = st; in_valid = iv; in_data = d; win_ready = wr;
      #1;
      pending = (m_emit > m_acc);
      odd_r   = ((m_pix / IMG_W) % 2) == 1;
      odd_c   = ((m_pix % IMG_W) % 2) == 1;
      exp_rdy = (m_phase == M_ROW) && !(odd_r && odd_c && pending && !wr);

      check("busy", busy, (m_phase == M_ROW) || (m_phase == M_DRAIN));
      check("frame_done", frame_done, m_phase == M_DONE);
      check("win_valid", win_valid, pending);
      check("in_ready", in_ready, exp_rdy);
      if (m_just_reset) begin
         check("rst_p0", win_p0, 0);
         check("rst_p1", win_p1, 0);
         check("rst_p2", win_p2, 0);
         check("rst_p3", win_p3, 0);
         check("rst_last", win_last, 0);
      end
      if (pending) begin
         k   = m_acc;
         top = 2 * (k / (IMG_W / 2)) * IMG_W + 2 * (k % (IMG_W / 2));
         check("win_p0", win_p0, pix[top]);
         check("win_p1", win_p1, pix[top + 1]);
         check("win_p2", win_p2, pix[top + IMG_W]);
         check("win_p3", win_p3, pix[top + IMG_W + 1]);
         check("win_last", win_last, k == NWIN - 1);
      end

      m_just_reset = 1'b0;
      take = pending && wr;
      if (rst) begin
         m_phase = M_IDLE; m_pix = 0; m_emit = 0; m_acc = 0;
         m_just_reset = 1'b1;
      end else begin
         case (m_phase)
            M_IDLE: if (st) begin
               m_phase = M_ROW; m_pix = 0; m_emit = 0; m_acc = 0;
            end
            M_ROW: begin
               if (take) m_acc++;
               if (iv && exp_rdy) begin
                  pix[m_pix] = d;
                  if (odd_r && odd_c) m_emit++;
                  m_pix++;
                  if (m_pix == NPIX) m_phase = M_DRAIN;
               end
            end
            M_DRAIN: if (take) begin
               m_acc++;
               if (m_acc == NWIN) m_phase = M_DONE;
            end
            default: m_phase = M_IDLE;
         endcase
      end
   endtask

   task automatic run_frame(input int base, input int vpct, input int rpct,
                            input int abort_at, input int stray_pct, input bit seq_data);
      int budget = 0;
      int dones = 0;
      logic [DATA_W-1:0] d;
      run_cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
      while (m_phase != M_IDLE && budget < 2000) begin
         budget++;
         d = seq_data ? DATA_W'(base + m_pix) : DATA_W'($urandom);
         if (abort_at >= 0 && m_pix == abort_at) begin
            run_cycle(1'b1, 1'b0, 1'b1, d, 1'b1);
            run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
            check("abort_no_done", dones, 0);
            return;
         end
         if (m_phase == M_DONE) dones++;
         run_cycle(1'b0, ($urandom_range(0, 99) < stray_pct),
                   ($urandom_range(0, 99) < vpct), d,
                   ($urandom_range(0, 99) < rpct));
      end
      check("frame_timeout", budget < 2000, 1);
      check("frame_done_count", dones, 1);
      check("windows_accepted", m_acc, NWIN);
   endtask

   initial begin
      run_cycle(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
      run_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b1, 16'h55aa, 1'b1);

      run_frame(0, 100, 100, -1, 0, 1'b1);     // basic, full throughput
      run_frame(0, 100, 25, -1, 0, 1'b1);      // window backpressure
      run_frame(0, 40, 100, -1, 0, 1'b1);      // input gaps
      run_frame(0, 100, 100, -1, 40, 1'b1);    // start while busy
      run_frame(0, 100, 100, 7, 0, 1'b1);      // reset mid-frame
      run_frame(100, 100, 100, -1, 0, 1'b1);   // clean frame after reset
      run_frame(200, 100, 100, -1, 0, 1'b1);   // back-to-back

      for (int f = 0; f < 12; f++) begin
         run_frame(0, $urandom_range(20, 100), $urandom_range(20, 100),
                   ($urandom_range(0, 5) == 0) ? $urandom_range(0, NPIX - 1) : -1,
                   $urandom_range(0, 30), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
